pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_if.sv | 36 +++
 rtl/pipe_stage_buf.sv | 126 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake and payload bundle for pipe_stage_buf.
// master: upstream/downstream environment side; slave: the stage itself.
interface pipe_stage_buf_if #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 15,
    parameter int INST_W     = 32,
    parameter int INST_OUT_W = 12,
    parameter int CNT_W      = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [INST_W-1:0]     in_inst;
    logic [CTRL_W-1:0]     in_ctrl;
    logic [DATA_W-1:0]     in_alu;
    logic [DATA_W-1:0]     in_a;
    logic [DATA_W-1:0]     in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_OUT_W-1:0] out_inst;
    logic [CTRL_W-1:0]     out_ctrl;
    logic [DATA_W-1:0]     out_alu;
    logic [DATA_W-1:0]     out_a;
    logic [DATA_W-1:0]     out_b;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output flush, in_valid, in_inst, in_ctrl, in_alu, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_inst, out_ctrl, out_alu, out_a, out_b, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_inst, in_ctrl, in_alu, in_a, in_b, out_ready,
        output in_ready, out_valid, out_inst, out_ctrl, out_alu, out_a, out_b, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one-entry pipeline register with optional skid entry.
// Build option: define PIPE_STAGE_BUF_SKID_EN to add the skid entry S and a
// registered in_ready (= !S.valid); otherwise in_ready is combinational
// (out_ready | !M.valid). Beats leave in acceptance order, one-cycle latency.
module pipe_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 15,
    parameter int INST_W     = 32,
    parameter int INST_OUT_W = 12,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_buf_if.slave bus
);
    localparam int PW = INST_OUT_W + CTRL_W + 3 * DATA_W;

`ifdef PIPE_STAGE_BUF_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
`else
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE} state_t;
`endif

    state_t          state_q;
    logic            m_valid_q;
    logic [PW-1:0]   m_data_q;
    logic            rdy_q;      // low in reset, gates in_ready until first edge after release
    logic [CNT_W-1:0] stall_cnt_q;
    logic [PW-1:0]   in_data;
    logic            in_xfer;
    logic            out_xfer;
    logic            unused_inst_hi;

    // Upper instruction bits are intentionally dropped when narrowing.
    assign unused_inst_hi = ^bus.in_inst;

    assign in_data  = {bus.in_inst[INST_OUT_W-1:0], bus.in_ctrl, bus.in_alu, bus.in_a, bus.in_b};
    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = m_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic            s_valid_q;
    logic [PW-1:0]   s_data_q;
    assign bus.in_ready = rdy_q;
`else
    assign bus.in_ready = rdy_q & (bus.out_ready | ~m_valid_q);
`endif

    assign bus.out_valid = m_valid_q;
    assign {bus.out_inst, bus.out_ctrl, bus.out_alu, bus.out_a, bus.out_b} = m_data_q;
    assign bus.stall_cnt = stall_cnt_q;

    // Occupancy state machine and storage; flush overrides every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            rdy_q     <= 1'b0;
`ifdef PIPE_STAGE_BUF_SKID_EN
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
`endif
        end else if (bus.flush) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            rdy_q     <= 1'b1;
`ifdef PIPE_STAGE_BUF_SKID_EN
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
`endif
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_q   <= ST_ONE;
                        m_valid_q <= 1'b1;
                        m_data_q  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_data_q <= in_data;
`ifdef PIPE_STAGE_BUF_SKID_EN
                    end else if (in_xfer) begin
                        state_q   <= ST_FULL;
                        s_valid_q <= 1'b1;
                        s_data_q  <= in_data;
                        rdy_q     <= 1'b0;
`endif
                    end else if (out_xfer) begin
                        // Payload is left in place so outputs keep their last values.
                        state_q   <= ST_EMPTY;
                        m_valid_q <= 1'b0;
                    end
                end
`ifdef PIPE_STAGE_BUF_SKID_EN
                ST_FULL: begin
                    if (out_xfer) begin
                        state_q   <= ST_ONE;
                        m_data_q  <= s_data_q;
                        s_valid_q <= 1'b0;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q   <= ST_EMPTY;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Back-pressure counter: saturating, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (m_valid_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: table-driven stream plus hand-written
// back-pressure, flush, throughput, saturation and async-reset sequences.
// Output beats are checked against a scoreboard queue filled on acceptance.
module tb_pipe_stage_buf;
    localparam int DW = 32;
    localparam int CW = 15;
    localparam int IW = 32;
    localparam int OW = 12;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW), .INST_W(IW), .INST_OUT_W(OW), .CNT_W(NW)) bus ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW), .INST_W(IW), .INST_OUT_W(OW), .CNT_W(2))  bus2 ();

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .INST_W(IW), .INST_OUT_W(OW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .INST_W(IW), .INST_OUT_W(OW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        logic [OW-1:0] inst;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] alu;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } beat_t;

    typedef struct {
        logic [IW-1:0] inst;
        logic [OW-1:0] exp_inst;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] alu;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } vec_t;

    beat_t sb_q[$];
    beat_t cur_exp;
    beat_t exp_b;
    vec_t  tbl[6];
    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] inst, input logic [OW-1:0] exp_inst,
                         input logic [CW-1:0] ctrl, input logic [DW-1:0] alu,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_ctrl  = ctrl;
        bus.in_alu   = alu;
        bus.in_a     = a;
        bus.in_b     = b;
        cur_exp.inst = exp_inst;
        cur_exp.ctrl = ctrl;
        cur_exp.alu  = alu;
        cur_exp.a    = a;
        cur_exp.b    = b;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen
    // here are the transfers of the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got alu=0x%0h, required no beat", bus.out_alu);
                end else begin
                    exp_b = sb_q.pop_front();
                    $display("out beat %0d: inst=0x%0h ctrl=0x%0h alu=0x%0h a=0x%0h b=0x%0h",
                             n_out, bus.out_inst, bus.out_ctrl, bus.out_alu, bus.out_a, bus.out_b);
                    if (bus.out_inst !== exp_b.inst || bus.out_ctrl !== exp_b.ctrl ||
                        bus.out_alu !== exp_b.alu || bus.out_a !== exp_b.a || bus.out_b !== exp_b.b) begin
                        errors++;
                        $display("FAIL sb_beat%0d: got inst=0x%0h alu=0x%0h a=0x%0h b=0x%0h, expected inst=0x%0h alu=0x%0h a=0x%0h b=0x%0h",
                                 n_out, bus.out_inst, bus.out_alu, bus.out_a, bus.out_b,
                                 exp_b.inst, exp_b.alu, exp_b.a, exp_b.b);
                    end
                end
            end
            if (bus.flush) begin
                sb_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(cur_exp);
                n_in++;
            end
        end
    end

    initial begin
        int in0;
        int out0;
        int tgt;
        bit ok;

        tbl[0] = '{32'hABCDE123, 12'h123, 15'h7FFF, 32'hDEADBEEF, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[1] = '{32'h00000FFF, 12'hFFF, 15'h0000, 32'h0000_0001, 32'h1111_1111, 32'h2222_2222};
        tbl[2] = '{32'hFFFFF000, 12'h000, 15'h2AAA, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        tbl[3] = '{32'h12345678, 12'h678, 15'h5555, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[4] = '{32'h00000000, 12'h000, 15'h0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{32'h80000001, 12'h001, 15'h4000, 32'h7FFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0};

        bus.flush = 1'b0;  bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.in_inst = '0; bus2.in_ctrl = '0; bus2.in_alu = '0; bus2.in_a = '0; bus2.in_b = '0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_out_alu", bus.out_alu, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_before_first_edge", bus.in_ready, 0);
        step();
        chk("in_ready_after_release", bus.in_ready, 1);

        // Single beat, one-cycle latency, hold on empty
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0, 12'h0, 15'h0, 32'h1234, 32'h0, 32'h0);
        step();
        bus.in_valid = 1'b0;
        chk("single_out_valid", bus.out_valid, 1);
        chk("single_out_alu", bus.out_alu, 32'h1234);
        step();
        chk("single_out_valid_after", bus.out_valid, 0);
        chk("single_alu_held", bus.out_alu, 32'h1234);

        // Table-driven stream at full rate
        in0 = n_in;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].inst, tbl[i].exp_inst, tbl[i].ctrl, tbl[i].alu, tbl[i].a, tbl[i].b);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("table_accepted", n_in - in0, 6);
        chk("table_drained", sb_q.size(), 0);

        // Back-pressure: A, B, C offered with out_ready low
        bus.out_ready = 1'b0;
        in0 = n_in;
        drive(1'b1, 32'hA0A, 12'hA0A, 15'h0A, 32'hA, 32'hA1, 32'hA2);
        step();
        drive(1'b1, 32'hB0B, 12'hB0B, 15'h0B, 32'hB, 32'hB1, 32'hB2);
        step();
        drive(1'b1, 32'hC0C, 12'hC0C, 15'h0C, 32'hC, 32'hC1, 32'hC2);
        for (int i = 0; i < 4; i++) step();
`ifdef PIPE_STAGE_BUF_SKID_EN
        chk("bp_accepted", n_in - in0, 2);
        tgt = in0 + 3;
`else
        chk("bp_accepted", n_in - in0, 1);
        tgt = in0 + 2;
`endif
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_alu_is_A", bus.out_alu, 32'hA);
        chk("stall_cnt_5", bus.stall_cnt, 5);
        bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (n_in >= tgt) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
        chk("bp_C_accepted_in_time", ok, 1);
        for (int i = 0; i < 4; i++) step();
        chk("bp_drained", sb_q.size(), 0);
        chk("bp_out_valid_idle", bus.out_valid, 0);

        // Flush while holding beats; beat offered during flush is discarded
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hE0E, 12'hE0E, 15'h0E, 32'hE, 32'hE1, 32'hE2);
        step();
        drive(1'b1, 32'hF0F, 12'hF0F, 15'h0F, 32'hF, 32'hF1, 32'hF2);
        step();
        drive(1'b1, 32'hD0D, 12'hD0D, 15'h0D, 32'hD, 32'hD1, 32'hD2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_out_alu", bus.out_alu, 0);
        chk("flush_out_inst", bus.out_inst, 0);
        chk("flush_out_b", bus.out_b, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        out0 = n_out;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("flush_no_beat_out", n_out - out0, 0);

        // Saturating counter on the 2-bit instance
        bus2.in_valid = 1'b1;
        bus2.in_alu = 32'h55;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        chk("cnt2_out_valid", bus2.out_valid, 1);
        step();
        step();
        chk("cnt2_after2", bus2.stall_cnt, 2);
        for (int i = 0; i < 8; i++) step();
        chk("cnt2_saturated", bus2.stall_cnt, 3);

        // Throughput: 100 beats in 101 cycles
        in0 = n_in;
        out0 = n_out;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 101; c++) begin
            if (n_in - in0 < 100)
                drive(1'b1, 32'(n_in - in0), OW'(n_in - in0), 15'h1, 32'(n_in - in0), 32'h5, 32'h6);
            else
                bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        chk("tput_in_100", n_in - in0, 100);
        chk("tput_out_100_in_101", n_out - out0, 100);
        chk("tput_drained", sb_q.size(), 0);

        // Asynchronous reset while beats are held
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h777, 12'h777, 15'h7, 32'h77, 32'h71, 32'h72);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_stall_cnt", bus.stall_cnt, 0);
        chk("arst_out_alu", bus.out_alu, 0);
        sb_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_in_ready_release", bus.in_ready, 1);
        chk("arst_no_beat", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
